// File: rtl/drive_power_mode_ctrl_pkg.sv
// Shared encodings for the drive power/mode sequencer: mode codes, manual
// engine one-hot states and the sequencer FSM states.
package drive_pkg;

  localparam logic [1:0] MODE_MAN  = 2'b00;
  localparam logic [1:0] MODE_SEMI = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [3:0] ST_UNSTARTING = 4'b0001;
  localparam logic [3:0] ST_STARTING   = 4'b0010;
  localparam logic [3:0] ST_MOVING     = 4'b0100;
  localparam logic [3:0] ST_POWER_OFF  = 4'b1000;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_HOLD     = 3'd1,
    S_WAIT_REL = 3'd2,
    S_ON       = 3'd3,
    S_SWITCH   = 3'd4
  } state_t;

  // The reserved switch setting falls back to manual at power-on.
  function automatic logic [1:0] sanitize_mode(input logic [1:0] sw);
    return (sw == MODE_RSVD) ? MODE_MAN : sw;
  endfunction

  // Enable vector ordered {auto, semi, man}; never more than one bit set.
  function automatic logic [2:0] mode_enables(input logic [1:0] m);
    logic [2:0] en;
    en = 3'b000;
    case (m)
      MODE_MAN:  en = 3'b001;
      MODE_SEMI: en = 3'b010;
      MODE_AUTO: en = 3'b100;
      default:   en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/drive_power_mode_ctrl_if.sv
// Engine-side bundle: power enables out to the three driving engines and
// their status / signal vectors back in.
interface drive_engine_if;
  logic [3:0] man_state;
  logic       semi_idle;
  logic       auto_idle;
  logic [3:0] man_ans;
  logic [3:0] semi_ans;
  logic [3:0] auto_ans;
  logic       man_en;
  logic       semi_en;
  logic       auto_en;

  modport master (
    output man_en, semi_en, auto_en,
    input  man_state, semi_idle, auto_idle, man_ans, semi_ans, auto_ans
  );

  modport slave (
    input  man_en, semi_en, auto_en,
    output man_state, semi_idle, auto_idle, man_ans, semi_ans, auto_ans
  );
endinterface

// File: rtl/drive_power_mode_ctrl_btn_debounce.sv
// Two-flop synchronizer followed by a stability debouncer; `changed` pulses
// for one cycle whenever the debounced level updates.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // Any return to the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      changed <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level   <= sync_b;
        changed <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/drive_power_mode_ctrl.sv
// Power and mode sequencer: long-press power-on, idle/stall/press power-off,
// stationary-only engine switching and the engine signal-vector mux.
module drive_power_mode_ctrl
  import drive_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int HOLD_CYC     = 100_000_000,
  parameter int IDLE_CYC     = 1_000_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         power_btn,
  input  logic [1:0]   mode_sw,
  drive_engine_if.master eng,
  output logic [1:0]   mode,
  output logic         power_now,
  output logic [3:0]   answer
);

  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam int IW = $clog2(IDLE_CYC) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYC);

  logic          btn_lvl;
  logic          btn_chg;
  logic [1:0]    msw_lvl;
  logic [1:0]    msw_chg;
  logic          press;
  logic          mode_chg;

  state_t        state;
  logic [1:0]    target;
  logic [2:0]    en_q;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idle_cnt;

  logic [3:0]    sel_ans;
  logic          stationary;
  logic          stall;
  logic          idle_hit;
  logic          switch_req;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_btn (
    .clk     (clk),
    .rst     (rst),
    .raw     (power_btn),
    .level   (btn_lvl),
    .changed (btn_chg)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_msw1 (
    .clk     (clk),
    .rst     (rst),
    .raw     (mode_sw[1]),
    .level   (msw_lvl[1]),
    .changed (msw_chg[1])
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_msw0 (
    .clk     (clk),
    .rst     (rst),
    .raw     (mode_sw[0]),
    .level   (msw_lvl[0]),
    .changed (msw_chg[0])
  );

  assign press    = btn_chg & btn_lvl;
  assign mode_chg = |msw_chg;

  always_comb begin
    sel_ans    = 4'b0000;
    stationary = 1'b0;
    case (mode)
      MODE_MAN: begin
        sel_ans    = eng.man_ans;
        stationary = (eng.man_state == ST_UNSTARTING);
      end
      MODE_SEMI: begin
        sel_ans    = eng.semi_ans;
        stationary = eng.semi_idle;
      end
      MODE_AUTO: begin
        sel_ans    = eng.auto_ans;
        stationary = eng.auto_idle;
      end
      default: begin
        sel_ans    = 4'b0000;
        stationary = 1'b0;
      end
    endcase
  end

  assign stall      = (mode == MODE_MAN) && (eng.man_state == ST_POWER_OFF);
  assign idle_hit   = (idle_cnt == IDLE_MAX);
  assign switch_req = (msw_lvl != mode) && (msw_lvl != MODE_RSVD) && stationary;

  assign answer = ((state == S_ON) || (state == S_WAIT_REL)) ? sel_ans : 4'b0000;

  assign eng.man_en  = en_q[0];
  assign eng.semi_en = en_q[1];
  assign eng.auto_en = en_q[2];

  // Sequencer; in ON the power-off causes are checked in priority order
  // press > stall > timeout before a pending mode switch is honoured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_OFF;
      mode      <= MODE_MAN;
      target    <= MODE_MAN;
      power_now <= 1'b0;
      en_q      <= 3'b000;
      hold_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        S_OFF: begin
          en_q      <= 3'b000;
          power_now <= 1'b0;
          idle_cnt  <= '0;
          if (btn_lvl) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end

        S_HOLD: begin
          idle_cnt <= '0;
          hold_cnt <= hold_cnt + 1'b1;
          if (!btn_lvl) begin
            state <= S_OFF;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= S_WAIT_REL;
            mode      <= sanitize_mode(msw_lvl);
            en_q      <= mode_enables(sanitize_mode(msw_lvl));
            power_now <= 1'b1;
          end
        end

        // The power-on press must be released before it can count again.
        S_WAIT_REL: begin
          idle_cnt <= '0;
          if (!btn_lvl) begin
            state <= S_ON;
          end
        end

        S_ON: begin
          if (press || stall || idle_hit) begin
            state     <= S_OFF;
            en_q      <= 3'b000;
            power_now <= 1'b0;
            idle_cnt  <= '0;
          end else if (switch_req) begin
            state    <= S_SWITCH;
            target   <= msw_lvl;
            en_q     <= 3'b000;
            idle_cnt <= '0;
          end else if ((sel_ans != 4'b0000) || mode_chg) begin
            idle_cnt <= '0;
          end else if (!idle_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        // One all-off cycle lets the old engine fall back to power_off.
        S_SWITCH: begin
          mode     <= target;
          en_q     <= mode_enables(target);
          idle_cnt <= '0;
          state    <= S_ON;
        end

        default: begin
          state     <= S_OFF;
          en_q      <= 3'b000;
          power_now <= 1'b0;
          idle_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_power_mode_ctrl.sv
// Scenario bench for drive_power_mode_ctrl with shortened timing constants;
// expected output snapshots are queued with the stimulus and popped at checks.
module tb_drive_power_mode_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int IDLE = 50;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } sb_entry_t;

  logic       clk;
  logic       rst;
  logic       power_btn;
  logic [1:0] mode_sw;
  logic [1:0] mode;
  logic       power_now;
  logic [3:0] answer;

  int n_checks;
  int n_fail;
  sb_entry_t sb[$];

  drive_engine_if eng();

  drive_power_mode_ctrl #(
    .DEBOUNCE_CYC (DB),
    .HOLD_CYC     (HOLD),
    .IDLE_CYC     (IDLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .power_btn (power_btn),
    .mode_sw   (mode_sw),
    .eng       (eng),
    .mode      (mode),
    .power_now (power_now),
    .answer    (answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout {mode, power_now, auto_en, semi_en, man_en, answer}.
  function automatic logic [9:0] expect_v(input logic [1:0] m, input logic p,
                                          input logic [2:0] en, input logic [3:0] a);
    return {m, p, en, a};
  endfunction

  function automatic logic [9:0] observe();
    return {mode, power_now, eng.auto_en, eng.semi_en, eng.man_en, answer};
  endfunction

  function automatic sb_entry_t mk(input string tag, input logic [9:0] val);
    sb_entry_t e;
    e.tag = tag;
    e.val = val;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    power_btn     = 1'b0;
    mode_sw       = 2'b00;
    eng.man_state = 4'b0001;
    eng.semi_idle = 1'b1;
    eng.auto_idle = 1'b1;
    eng.man_ans   = 4'h0;
    eng.semi_ans  = 4'h0;
    eng.auto_ans  = 4'h0;
    tick(3);
    rst = 1'b1;
    tick(1);
  endtask

  // Long press with the given switch setting; leaves the DUT in ON.
  task automatic power_on(input logic [1:0] sw);
    mode_sw = sw;
    tick(10);
    power_btn = 1'b1;
    tick(30);
    power_btn = 1'b0;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_checks++;
      if ($countones({eng.auto_en, eng.semi_en, eng.man_en}) > 1) begin
        n_fail++;
        $display("[TB] FAIL enable_onehot: got %b want at most one bit set",
                 {eng.auto_en, eng.semi_en, eng.man_en});
      end
    end
  end

  task automatic test_reset();
    sb_entry_t e;
    rst          = 1'b0;
    eng.man_ans  = 4'hF;
    eng.semi_ans = 4'hF;
    eng.auto_ans = 4'hF;
    sb.push_back(mk("reset_held", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(3);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    rst = 1'b1;
    sb.push_back(mk("reset_released", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(2);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_power_on();
    sb_entry_t e;
    do_reset();
    mode_sw      = 2'b01;
    eng.semi_ans = 4'b0101;
    tick(10);
    power_btn = 1'b1;
    sb.push_back(mk("pwr_still_holding", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(25);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    sb.push_back(mk("pwr_on_semi", expect_v(2'b01, 1'b1, 3'b010, 4'b0101)));
    tick(4);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    power_btn = 1'b0;
    sb.push_back(mk("pwr_after_release", expect_v(2'b01, 1'b1, 3'b010, 4'b0101)));
    sb.push_back(mk("pwr_release_long", expect_v(2'b01, 1'b1, 3'b010, 4'b0101)));
    tick(15);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(30);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_reserved_mode();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'b0011;
    power_on(2'b11);
    sb.push_back(mk("rsvd_maps_manual", expect_v(2'b00, 1'b1, 3'b001, 4'b0011)));
    sb.push_back(mk("rsvd_no_switch", expect_v(2'b00, 1'b1, 3'b001, 4'b0011)));
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(20);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_short_press();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'hF;
    power_btn   = 1'b1;
    sb.push_back(mk("short_during", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    sb.push_back(mk("short_after", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(10);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    power_btn = 1'b0;
    tick(30);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_glitch();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'hF;
    power_btn   = 1'b1;
    tick(2);
    power_btn = 1'b0;
    sb.push_back(mk("glitch_ignored", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(30);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_mode_change();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'b0001;
    power_on(2'b00);
    eng.man_state = 4'b0100;
    eng.auto_ans  = 4'b0010;
    mode_sw       = 2'b10;
    sb.push_back(mk("mc_moving_blocked", expect_v(2'b00, 1'b1, 3'b001, 4'b0001)));
    tick(15);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    eng.man_state = 4'b0001;
    eng.man_ans   = 4'h0;
    sb.push_back(mk("mc_gap_cycle", expect_v(2'b00, 1'b1, 3'b000, 4'h0)));
    sb.push_back(mk("mc_auto_on", expect_v(2'b10, 1'b1, 3'b100, 4'b0010)));
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    eng.semi_ans = 4'b0100;
    mode_sw      = 2'b01;
    sb.push_back(mk("mc2_before", expect_v(2'b10, 1'b1, 3'b100, 4'b0010)));
    sb.push_back(mk("mc2_gap", expect_v(2'b10, 1'b1, 3'b000, 4'h0)));
    sb.push_back(mk("mc2_semi_on", expect_v(2'b01, 1'b1, 3'b010, 4'b0100)));
    tick(6);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_stall();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'b0001;
    power_on(2'b00);
    sb.push_back(mk("stall_before", expect_v(2'b00, 1'b1, 3'b001, 4'b0001)));
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    eng.man_state = 4'b1000;
    sb.push_back(mk("stall_off", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_press_off();
    sb_entry_t e;
    do_reset();
    eng.semi_ans = 4'b0101;
    power_on(2'b01);
    power_btn = 1'b1;
    sb.push_back(mk("press_not_yet", expect_v(2'b01, 1'b1, 3'b010, 4'b0101)));
    sb.push_back(mk("press_off", expect_v(2'b01, 1'b0, 3'b000, 4'h0)));
    tick(6);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    power_btn = 1'b0;
    tick(20);
  endtask

  task automatic test_priority();
    sb_entry_t e;
    do_reset();
    power_on(2'b00);
    power_btn = 1'b1;
    mode_sw   = 2'b10;
    sb.push_back(mk("prio_before", expect_v(2'b00, 1'b1, 3'b001, 4'h0)));
    sb.push_back(mk("prio_press_wins", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(6);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    power_btn = 1'b0;
    tick(20);
  endtask

  task automatic test_idle_timeout();
    sb_entry_t e;
    do_reset();
    power_on(2'b00);
    sb.push_back(mk("idle_still_on", expect_v(2'b00, 1'b1, 3'b001, 4'h0)));
    sb.push_back(mk("idle_timed_out", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(45);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(5);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end

    do_reset();
    power_on(2'b00);
    tick(37);
    eng.man_ans = 4'b0001;
    sb.push_back(mk("idle_pulse_mux", expect_v(2'b00, 1'b1, 3'b001, 4'b0001)));
    sb.push_back(mk("idle_delayed_on", expect_v(2'b00, 1'b1, 3'b001, 4'h0)));
    sb.push_back(mk("idle_delayed_off", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(1);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    eng.man_ans = 4'h0;
    tick(45);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(9);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  task automatic test_reset_mid_hold();
    sb_entry_t e;
    do_reset();
    eng.man_ans = 4'hF;
    power_btn   = 1'b1;
    tick(15);
    rst = 1'b0;
    sb.push_back(mk("rhold_cleared", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    sb.push_back(mk("rhold_restart_wait", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    sb.push_back(mk("rhold_full_hold", expect_v(2'b00, 1'b1, 3'b001, 4'hF)));
    tick(1);
    rst = 1'b1;
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(24);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    tick(4);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    power_btn = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_mid_switch();
    sb_entry_t e;
    do_reset();
    power_on(2'b00);
    eng.auto_ans = 4'b0010;
    mode_sw      = 2'b10;
    sb.push_back(mk("rsw_in_switch", expect_v(2'b00, 1'b1, 3'b000, 4'h0)));
    sb.push_back(mk("rsw_no_partial", expect_v(2'b00, 1'b0, 3'b000, 4'h0)));
    tick(7);
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b want %b", e.tag, observe(), e.val);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    power_btn     = 1'b0;
    mode_sw       = 2'b00;
    eng.man_state = 4'b0001;
    eng.semi_idle = 1'b1;
    eng.auto_idle = 1'b1;
    eng.man_ans   = 4'h0;
    eng.semi_ans  = 4'h0;
    eng.auto_ans  = 4'h0;

    test_reset();
    test_power_on();
    test_reserved_mode();
    test_short_press();
    test_glitch();
    test_mode_change();
    test_stall();
    test_press_off();
    test_priority();
    test_idle_timeout();
    test_reset_mid_hold();
    test_reset_mid_switch();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries left want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drive_power_mode_ctrl.md
# drive_power_mode_ctrl

Top-level power and mode sequencer for the car controller. It debounces the power button and enforces a long-press power-on. It owns the `power_input` enable of the driving engines (manual, semi-auto, auto). It selects exactly one engine at a time, allows mode changes only while the car is stationary, and muxes the selected engine's 4-bit signal vector `{right, left, back, forward}` to the LED/output stage.

## Interface
- `DEBOUNCE_CYC`, 2_000_000, cycles a synchronized input must be stable (20 ms @ 100 MHz).
- `HOLD_CYC`, 100_000_000, debounced-press duration required to power on (1 s).
- `IDLE_CYC`, 1_000_000_000, no-activity cycles in ON before auto power-off (10 s).
- `clk  in  1  100 MHz system clock (P17).`
- `rst  in  1  synchronous, active-low reset.`
- `power_btn  in  1  raw power push-button.`
- `mode_sw  in  2  raw mode switches: 00 manual, 01 semi, 10 auto, 11 reserved.`
- `man_state  in  4  one-hot manual engine state: 0001 unstarting, 0010 starting, 0100 moving, 1000 power_off.`
- `semi_idle, auto_idle  in  1  each: engine stationary.`
- `man_ans, semi_ans, auto_ans  in  4  each: engine signal vectors.`
- `man_en, semi_en, auto_en  out  1  each: drive the engine's `power_input`.`
- `mode  out  2  current mode.`
- `power_now  out  1  car powered.`
- `answer  out  4  muxed signal vector.`

## Operation
- Inputs: `power_btn` and `mode_sw` each pass through a 2-flop synchronizer, then a debouncer. The debounced level updates only after the input has been stable for `DEBOUNCE_CYC` cycles. `press` is a 1-cycle pulse on a debounced 0→1 edge.
- FSM states: OFF, HOLD, WAIT_REL, ON, SWITCH.
- OFF:
  - Outputs: all enables 0, `power_now` 0, `answer` 0.
  - Debounced btn=1 → HOLD and clear the hold counter.
- HOLD:
  - Counter increments each cycle.
  - Btn=0 before the count reaches `HOLD_CYC` → OFF.
  - Count = `HOLD_CYC`-1 with btn still 1 → WAIT_REL.
  - On that transition: latch `mode` from debounced `mode_sw` (11 → 00) and set `power_now`=1.
- WAIT_REL:
  - Powered; the selected enable is 1.
  - Btn=0 → ON. The button is ignored until released, so the power-on press never powers off.
- ON:
  - `press` → OFF (highest priority).
  - Else `mode`=manual and `man_state`=1000 → OFF (engine stall).
  - Else the idle counter reaches `IDLE_CYC` → OFF.
  - Else debounced `mode_sw` ≠ `mode`, `mode_sw` ≠ 11, and the current engine is stationary → SWITCH. Stationary means `man_state`=0001 for manual, else `semi_idle`/`auto_idle`.
- Idle counter:
  - Clears whenever selected `answer` ≠ 0, any `press` occurs, or a debounced `mode_sw` change occurs.
  - Saturates at `IDLE_CYC`.
  - Held at 0 outside ON.
- SWITCH:
  - Exactly 1 cycle with all enables 0 and `answer`=0, so the old engine resets to power_off.
  - Next cycle: `mode` ← new value, then → ON with the new enable = 1.
  - A non-stationary engine defers the switch; the request stays pending as long as the switch differs.
- Output mux: `answer` = selected engine's vector when the state is ON or WAIT_REL, else 0.
- Enables are one-hot or all-zero, never two high at once.

## Timing
- Reset (`rst`=0 at posedge):
  - State OFF, `mode`=00, `power_now`=0, all enables 0, `answer`=0.
  - Debouncers cleared to 0.
  - Counters cleared to 0.
- All outputs are registered except `answer`, which is a combinational mux on registered state and the engine inputs.
- Button edge to debounced level: 2 + `DEBOUNCE_CYC` cycles.
- Debounced press to `power_now`=1: `HOLD_CYC` cycles.
- `press` in ON to `power_now`=0: 1 cycle.
- Mode change:
  - Debounced change while stationary → enables all 0 on cycle +1.
  - New enable = 1 and `mode` updated on cycle +2.
- Simultaneous events in ON: `press` beats stall, which beats timeout, which beats switch.
- Reset asserted mid-HOLD or mid-SWITCH → OFF on the next edge; no partial mode update.
- Counter widths: `$clog2` of the parameter value + 1; no wrap-around.

## Structure
- Package `drive_pkg` holds:
  - mode encodings (MODE_MAN, MODE_SEMI, MODE_AUTO);
  - manual one-hot states (ST_UNSTARTING…ST_POWER_OFF);
  - FSM state encodings.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYC`, with synchronizer) is instantiated 3× (btn, mode_sw[1], mode_sw[0]).
- Everything else lives in one FSM module.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `HOLD_CYC`=20, `IDLE_CYC`=50.
- Power-on:
  - Hold btn 30 cycles with `mode_sw`=01 → `power_now`=1, `semi_en`=1, `mode`=01.
  - Releasing gives no power-off.
- Short press: btn high 10 cycles from OFF → stays OFF, all outputs 0.
- Mode change while moving:
  - In manual with `man_state`=0100, set `mode_sw`=10 → no change.
  - Then `man_state`=0001 → one all-zero-enable cycle, then `auto_en`=1, `mode`=10.
- Stall and press-off:
  - Manual ON with `man_state`=1000 → `power_now`=0 next cycle.
  - Separately, a debounced press in ON → OFF in 1 cycle.
- Idle timeout: ON, `answer`=0, no inputs for 50 cycles → OFF; `man_ans`=0001 pulsed at cycle 40 delays the timeout by 40 cycles.
- Reset and glitch:
  - `rst`=0 mid-HOLD → OFF, counters 0.
  - A 2-cycle btn glitch shorter than `DEBOUNCE_CYC` is ignored.
